// File: rtl/seq_mul_iu_pkg.sv
// Shared definitions for the sequential multiply unit.
//   state_e   : FSM state encoding (idle, iterate, sign fix-up, result pulse)
//   DefWidth  : default operand width
//   ClaGroup  : bit width of one carry-lookahead group inside the adder
package seq_mul_iu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned ClaGroup = 4;

endpackage

// File: rtl/seq_mul_iu_if.sv
// Request/response bundle of the multiply unit.
//   start   : request, accepted only when the unit is not busy
//   a, b    : multiplicand / multiplier, sampled on the accepting edge
//   sig     : 1 = two's-complement operands, 0 = unsigned
//   busy    : operation in progress
//   done    : one-cycle result pulse
//   product : full 2*WIDTH result, held until the next accepted start or reset
//   ovf     : result does not fit in WIDTH bits in the selected mode
// master drives the request side, slave is the multiply unit.
interface seq_mul_iu_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sig;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 ovf;

    modport master (
        output start, a, b, sig,
        input  busy, done, product, ovf
    );

    modport slave (
        input  start, a, b, sig,
        output busy, done, product, ovf
    );
endinterface

// File: rtl/seq_mul_iu_cla.sv
// WIDTH-bit carry-lookahead adder: a ripple of 4-bit lookahead groups.
//   a_i, b_i : addends
//   cin_i    : carry into bit 0
//   sum_o    : WIDTH-bit sum
//   cout_o   : carry out of the top group
// WIDTH must be a multiple of the group size.
module seq_mul_iu_cla
    import seq_mul_iu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int unsigned NumGroups = WIDTH / ClaGroup;

    logic [WIDTH-1:0]     g;
    logic [WIDTH-1:0]     p;
    logic [WIDTH-1:0]     c;
    logic [NumGroups:0]   gc;  // carry into each group

    assign g     = a_i & b_i;
    assign p     = a_i ^ b_i;
    assign gc[0] = cin_i;

    for (genvar k = 0; k < NumGroups; k++) begin : g_grp
        localparam int unsigned Base = k * ClaGroup;
        logic g0, g1, g2, g3, p0, p1, p2, p3, ci;

        assign {g3, g2, g1, g0} = g[Base +: 4];
        assign {p3, p2, p1, p0} = p[Base +: 4];
        assign ci               = gc[k];

        assign c[Base]     = ci;
        assign c[Base + 1] = g0 | (p0 & ci);
        assign c[Base + 2] = g1 | (p1 & g0) | (p1 & p0 & ci);
        assign c[Base + 3] = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & ci);
        assign gc[k + 1]   = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0)
                           | (p3 & p2 & p1 & p0 & ci);
    end

    assign sum_o  = p ^ c;
    assign cout_o = gc[NumGroups];
endmodule

// File: rtl/seq_mul_iu.sv
// Multi-cycle radix-2 shift-add integer multiplier.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, overrides everything
//   bus : request/response bundle (slave side), see seq_mul_iu_if
// Operands are reduced to magnitudes on acceptance, multiplied unsigned over WIDTH
// iterations, then the sign is applied in a single fix-up cycle.
module seq_mul_iu
    import seq_mul_iu_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic        clk,
    input  logic        rst,
    seq_mul_iu_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 neg_q, neg_d;
    logic                 sig_q, sig_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q, ovf_d;

    // Accumulate adder: hi + (multiplier LSB ? multiplicand : 0).
    logic [WIDTH-1:0] acc_b, acc_sum;
    logic             acc_cout;

    assign acc_b = lo_q[0] ? mcand_q : '0;

    seq_mul_iu_cla #(.WIDTH(WIDTH)) u_acc (
        .a_i    (hi_q),
        .b_i    (acc_b),
        .cin_i  (1'b0),
        .sum_o  (acc_sum),
        .cout_o (acc_cout)
    );

    // Negator, split into two WIDTH halves. In FIX the halves are chained to negate the
    // 2*WIDTH product; otherwise each half independently negates one incoming operand.
    logic [WIDTH-1:0] neg_lo_in, neg_hi_in, neg_lo_sum, neg_hi_sum;
    logic             neg_lo_cout, neg_hi_cin, neg_hi_cout;
    logic             unused_neg_cout;

    always_comb begin
        if (state_q == StFix) begin
            neg_lo_in  = lo_q;
            neg_hi_in  = hi_q;
            neg_hi_cin = neg_lo_cout;
        end else begin
            neg_lo_in  = bus.a;
            neg_hi_in  = bus.b;
            neg_hi_cin = 1'b1;
        end
    end

    seq_mul_iu_cla #(.WIDTH(WIDTH)) u_neg_lo (
        .a_i    (~neg_lo_in),
        .b_i    ('0),
        .cin_i  (1'b1),
        .sum_o  (neg_lo_sum),
        .cout_o (neg_lo_cout)
    );

    seq_mul_iu_cla #(.WIDTH(WIDTH)) u_neg_hi (
        .a_i    (~neg_hi_in),
        .b_i    ('0),
        .cin_i  (neg_hi_cin),
        .sum_o  (neg_hi_sum),
        .cout_o (neg_hi_cout)
    );

    assign unused_neg_cout = neg_hi_cout;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1), exact as an unsigned value.
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             a_neg, b_neg, any_zero;

    assign a_neg    = bus.sig & bus.a[WIDTH-1];
    assign b_neg    = bus.sig & bus.b[WIDTH-1];
    assign mag_a    = a_neg ? neg_lo_sum : bus.a;
    assign mag_b    = b_neg ? neg_hi_sum : bus.b;
    assign any_zero = (bus.a == '0) | (bus.b == '0);

    // Signed result and overflow, meaningful in FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     prod_top;
    logic               ovf_fix;

    assign prod_fix = neg_q ? {neg_hi_sum, neg_lo_sum} : {hi_q, lo_q};
    assign prod_top = prod_fix[2*WIDTH-1:WIDTH-1];
    assign ovf_fix  = sig_q ? !((&prod_top) | ~(|prod_top))
                            : (|prod_fix[2*WIDTH-1:WIDTH]);

    logic accept;
    assign accept = bus.start & ((state_q == StIdle) | (state_q == StDone));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        sig_d     = sig_q;
        product_d = product_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            StIdle: ;
            StCalc: begin
                // {carry, hi, lo} >> 1 after the conditional add.
                hi_d  = {acc_cout, acc_sum[WIDTH-1:1]};
                lo_d  = {acc_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                product_d = prod_fix;
                ovf_d     = ovf_fix;
                state_d   = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            mcand_d = mag_a;
            lo_d    = mag_b;
            hi_d    = '0;
            cnt_d   = '0;
            neg_d   = (a_neg ^ b_neg) & ~any_zero;
            sig_d   = bus.sig;
            state_d = StCalc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            sig_q     <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            sig_q     <= sig_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy    = (state_q == StCalc) | (state_q == StFix);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_seq_mul_iu.sv
module tb_seq_mul_iu;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_mul_iu_if #(.WIDTH(16)) bus ();

    seq_mul_iu #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done; edges counts clock edges stepped while waiting.
    task automatic wait_done(output int edges, output bit to);
        edges = 0;
        to    = 1'b0;
        while (bus.done !== 1'b1) begin
            if (edges >= 60) begin
                to = 1'b1;
                break;
            end
            tick();
            edges++;
        end
    endtask

    // Issues one request; edges includes the accepting edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int edges, output bit to);
        int e;
        bus.a     = a;
        bus.b     = b;
        bus.sig   = s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(e, to);
        edges = e + 1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sig   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        total++;
        if (bus.product !== 32'h0) begin
            bad++;
            $display("FAIL reset_product: got %h want 00000000", bus.product);
        end
        total++;
        if (bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf: got %b want 0", bus.ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_max();
        int e;
        bit to;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.sig   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL umax_busy_after_accept: got %b want 1", bus.busy);
        end
        wait_done(e, to);
        e = e + 1;
        total++;
        if (to || e != 18) begin
            bad++;
            $display("FAIL umax_latency: got %0d edges (timeout=%0d) want 18", e, to);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL umax_busy_in_done: got %b want 0", bus.busy);
        end
        total++;
        if (bus.product !== 32'hFFFE0001) begin
            bad++;
            $display("FAIL umax_product: got %h want fffe0001", bus.product);
        end
        total++;
        if (bus.ovf !== 1'b1) begin
            bad++;
            $display("FAIL umax_ovf: got %b want 1", bus.ovf);
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL umax_done_pulse: got %b want 0", bus.done);
        end
        tick();
        tick();
        total++;
        if (bus.product !== 32'hFFFE0001) begin
            bad++;
            $display("FAIL umax_product_hold: got %h want fffe0001", bus.product);
        end
    endtask

    task automatic test_signed();
        int e;
        bit to;
        run_op(16'hFFFD, 16'h0005, 1'b1, e, to);
        total++;
        if (to || bus.product !== 32'hFFFFFFF1) begin
            bad++;
            $display("FAIL s_m3x5_product: got %h want fffffff1", bus.product);
        end
        total++;
        if (bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL s_m3x5_ovf: got %b want 0", bus.ovf);
        end
        run_op(16'h00FF, 16'h0100, 1'b0, e, to);
        total++;
        if (to || bus.product !== 32'h0000FF00 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL u_ff_x100: got %h ovf %b want 0000ff00 ovf 0", bus.product, bus.ovf);
        end
        run_op(16'h0000, 16'hFFFB, 1'b1, e, to);
        total++;
        if (to || bus.product !== 32'h0 || bus.ovf !== 1'b0 || e != 18) begin
            bad++;
            $display("FAIL s_zero: got %h ovf %b edges %0d want 00000000 ovf 0 edges 18",
                     bus.product, bus.ovf, e);
        end
    endtask

    task automatic test_min();
        int e;
        bit to;
        run_op(16'h8000, 16'h8000, 1'b1, e, to);
        total++;
        if (to || bus.product !== 32'h40000000) begin
            bad++;
            $display("FAIL s_min_sq_product: got %h want 40000000", bus.product);
        end
        total++;
        if (bus.ovf !== 1'b1) begin
            bad++;
            $display("FAIL s_min_sq_ovf: got %b want 1", bus.ovf);
        end
        run_op(16'h8000, 16'h0001, 1'b1, e, to);
        total++;
        if (to || bus.product !== 32'hFFFF8000) begin
            bad++;
            $display("FAIL s_min_x1_product: got %h want ffff8000", bus.product);
        end
        total++;
        if (bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL s_min_x1_ovf: got %b want 0", bus.ovf);
        end
    endtask

    task automatic test_ignore_busy();
        int pulses;
        pulses    = 0;
        bus.a     = 16'd7;
        bus.b     = 16'd9;
        bus.sig   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 40; i++) begin
            if (i == 5) begin
                bus.a     = 16'd2;
                bus.b     = 16'd2;
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                pulses++;
                total++;
                if (bus.product !== 32'h0000003F) begin
                    bad++;
                    $display("FAIL ignore_product: got %h want 0000003f", bus.product);
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL ignore_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        bit to;
        bus.a     = 16'd5;
        bus.b     = 16'd5;
        bus.sig   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_ctrl: got busy %b done %b want 0 0", bus.busy, bus.done);
        end
        total++;
        if (bus.product !== 32'h0) begin
            bad++;
            $display("FAIL midrst_product: got %h want 00000000", bus.product);
        end
        tick();
        run_op(16'd3, 16'd4, 1'b0, e, to);
        total++;
        if (to || bus.product !== 32'h0000000C || e != 18) begin
            bad++;
            $display("FAIL midrst_new_op: got %h edges %0d want 0000000c edges 18",
                     bus.product, e);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        bit to;
        bus.a     = 16'd2;
        bus.b     = 16'd3;
        bus.sig   = 1'b0;
        bus.start = 1'b1;
        tick();
        wait_done(e, to);
        total++;
        if (to || bus.product !== 32'h00000006) begin
            bad++;
            $display("FAIL b2b_first: got %h want 00000006", bus.product);
        end
        // start still high in the DONE cycle: the next op is taken on this edge.
        bus.a = 16'd4;
        bus.b = 16'd5;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy: got busy %b done %b want 1 0", bus.busy, bus.done);
        end
        wait_done(e, to);
        total++;
        if (to || bus.product !== 32'h00000014 || e != 17) begin
            bad++;
            $display("FAIL b2b_second: got %h wait %0d want 00000014 wait 17", bus.product, e);
        end
        tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sig   = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_min();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
